// File: rtl/main_rescale_acc_if.sv
// main_rescale_acc_if: operand tag, multiplier product and result handshake bundle.
interface main_rescale_acc_if #(
  parameter int PROD_WIDTH = 93,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 16
);
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic mul_ce;
  logic signed [PROD_WIDTH-1:0] prod;
  logic out_valid;
  logic out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic out_sat;
  logic [CNT_WIDTH-1:0] out_count;
  modport master (
    output in_valid, in_last, prod, out_ready,
    input in_ready, mul_ce, out_valid, out_data, out_sat, out_count
  );
  modport slave (
    input in_valid, in_last, prod, out_ready,
    output in_ready, mul_ce, out_valid, out_data, out_sat, out_count
  );
endinterface

// File: rtl/main_rescale_acc.sv
// main_rescale_acc: aligns tags with multiplier products, rounds each to integer scale and
// sums a group into a saturating accumulator, emitting one registered result per group.
module main_rescale_acc #(
  parameter int PROD_WIDTH = 93,
  parameter int FRAC_BITS = 32,
  parameter int OUT_WIDTH = 64,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic reset_n,
  main_rescale_acc_if.slave bus
);
  localparam logic signed [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [PROD_WIDTH:0] RMAX = OMAX;
  localparam logic signed [PROD_WIDTH:0] RMIN = OMIN;
  localparam logic signed [PROD_WIDTH:0] HALF = (PROD_WIDTH+1)'(1) << (FRAC_BITS-1);
  logic ce;
  logic tail_v;
  logic tail_l;
  logic clip;
  logic ovf;
  logic sat_d;
  logic [MUL_LATENCY-1:0] v_q;
  logic [MUL_LATENCY-1:0] l_q;
  logic signed [PROD_WIDTH:0] r_full;
  logic signed [OUT_WIDTH-1:0] r;
  logic signed [OUT_WIDTH:0] s_full;
  logic signed [OUT_WIDTH-1:0] sum_d;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic sat_q;
  logic out_sat_q;
  logic out_valid_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] out_count_q;
  assign ce = !out_valid_q || bus.out_ready;
  assign tail_v = v_q[MUL_LATENCY-1];
  assign tail_l = l_q[MUL_LATENCY-1];
  // one guard bit keeps the rounding increment from wrapping the most positive product
  assign r_full = ($signed({bus.prod[PROD_WIDTH-1], bus.prod}) + HALF) >>> FRAC_BITS;
  assign clip = r_full > RMAX || r_full < RMIN;
  assign r = r_full > RMAX ? OMAX : r_full < RMIN ? OMIN : r_full[OUT_WIDTH-1:0];
  assign s_full = {acc_q[OUT_WIDTH-1], acc_q} + {r[OUT_WIDTH-1], r};
  assign ovf = s_full[OUT_WIDTH] ^ s_full[OUT_WIDTH-1];
  assign sum_d = ovf ? (s_full[OUT_WIDTH] ? OMIN : OMAX) : s_full[OUT_WIDTH-1:0];
  assign sat_d = clip || ovf;
  assign cnt_d = cnt_q + CNT_WIDTH'(1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q <= '0;
      l_q <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q <= 1'b0;
      out_count_q <= '0;
    end else if (ce) begin
      v_q <= (v_q << 1) | MUL_LATENCY'(bus.in_valid);
      l_q <= (l_q << 1) | MUL_LATENCY'(bus.in_valid && bus.in_last);
      out_valid_q <= tail_v && tail_l;
      if (tail_v && tail_l) begin
        out_data_q <= sum_d;
        out_sat_q <= sat_q || sat_d;
        out_count_q <= cnt_d;
        acc_q <= '0;
        sat_q <= 1'b0;
        cnt_q <= '0;
      end else if (tail_v) begin
        acc_q <= sum_d;
        sat_q <= sat_q || sat_d;
        cnt_q <= cnt_d;
      end
    end
  end
  assign bus.in_ready = ce;
  assign bus.mul_ce = ce;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sat = out_sat_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_main_rescale_acc.sv
// tb_main_rescale_acc: directed and randomized checks of main_rescale_acc against a
// plain-arithmetic model of rounding, clamping and saturating group sums.
module tb_main_rescale_acc;
  localparam logic signed [127:0] MAXV = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINV = -MAXV - 128'sd1;
  localparam logic signed [92:0] PMAX = {1'b0, {92{1'b1}}};
  localparam logic signed [92:0] PMIN = {1'b1, {92{1'b0}}};
  typedef struct packed {
    logic signed [63:0] d;
    logic s;
    logic [15:0] c;
  } res_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic signed [92:0] op = '0;
  logic signed [92:0] mp [4] = '{default: '0};
  int mode = 0;
  int cyc = 0;
  int pass_cnt = 0;
  int total = 0;
  res_t got_q[$];
  res_t exp_q[$];
  int got_t[$];
  logic signed [127:0] m_acc = '0;
  bit m_sat = 1'b0;
  int m_cnt = 0;

  main_rescale_acc_if bus ();
  main_rescale_acc dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  assign bus.prod = mp[3];

  // multiplier stand-in: a ce-gated delay line whose contents survive reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mul_ce) begin
      mp[0] <= op;
      for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
    end
  end

  always @(posedge clk) begin
    #2;
    bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk)
    if (reset_n && bus.out_valid && bus.out_ready) begin
      got_q.push_back('{bus.out_data, bus.out_sat, bus.out_count});
      got_t.push_back(cyc);
    end

  function automatic logic signed [92:0] sc(input longint k);
    return 93'(k) <<< 32;
  endfunction

  function automatic logic signed [92:0] rnd93();
    return 93'({$urandom, $urandom, $urandom});
  endfunction

  function automatic void model_term(input logic signed [92:0] p, input bit last);
    logic signed [127:0] r;
    logic signed [127:0] s;
    bit st;
    r = p;
    r = (r + 128'sh8000_0000) >>> 32;
    st = 1'b0;
    if (r > MAXV) begin r = MAXV; st = 1'b1; end
    if (r < MINV) begin r = MINV; st = 1'b1; end
    s = m_acc + r;
    if (s > MAXV) begin s = MAXV; st = 1'b1; end
    if (s < MINV) begin s = MINV; st = 1'b1; end
    m_cnt++;
    if (last) begin
      exp_q.push_back('{s[63:0], m_sat | st, 16'(m_cnt)});
      m_acc = '0;
      m_sat = 1'b0;
      m_cnt = 0;
    end else begin
      m_acc = s;
      m_sat = m_sat | st;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin op = rnd93(); @(posedge clk); #1; end
  endtask

  task automatic send(input logic signed [92:0] p, input bit last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last = last;
    op = p;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    op = rnd93();
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: in_ready stayed 0, want 1 within 200 cycles");
    end else model_term(p, last);
  endtask

  task automatic drain(input int n, output bit ok);
    for (int i = 0; i < 4000 && got_q.size() < n; i++) tick(1);
    ok = got_q.size() >= n;
    tick(8);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    tick(3);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    total++; if (bus.out_data !== 64'd0) $display("FAIL reset_out_data: got %0d want 0", bus.out_data); else pass_cnt++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); else pass_cnt++;
    total++; if (bus.out_count !== 16'd0) $display("FAIL reset_out_count: got %0d want 0", bus.out_count); else pass_cnt++;
    total++; if ({bus.mul_ce, bus.in_ready} !== 2'b11) $display("FAIL reset_ce_ready: got %b want 11", {bus.mul_ce, bus.in_ready}); else pass_cnt++;
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single;
    int seen = 0;
    int width = 0;
    res_t r = '0;
    bus.in_valid = 1'b1;
    bus.in_last = 1'b1;
    op = sc(3);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin bus.in_valid = 1'b0; bus.in_last = 1'b0; op = rnd93(); end
      if (bus.out_valid) begin
        width++;
        if (seen == 0) begin seen = i; r = '{bus.out_data, bus.out_sat, bus.out_count}; end
      end
    end
    total++; if (seen !== 5) $display("FAIL single_latency: got %0d want 5", seen); else pass_cnt++;
    total++; if (width !== 1) $display("FAIL single_pulse_width: got %0d want 1", width); else pass_cnt++;
    total++; if (r.d !== 64'sd3) $display("FAIL single_data: got %0d want 3", r.d); else pass_cnt++;
    total++; if ({r.s, r.c} !== {1'b0, 16'd1}) $display("FAIL single_sat_count: got %b/%0d want 0/1", r.s, r.c); else pass_cnt++;
  endtask

  task automatic test_rounding;
    logic signed [92:0] ps [4] = '{93'sh8000_0000, -93'sh8000_0000, -93'sh1_8000_0000, 93'sh7FFF_FFFF};
    longint want [4] = '{1, 0, -1, 0};
    int base = got_q.size();
    bit ok;
    for (int i = 0; i < 4; i++) begin send(ps[i], 1'b1); idle(1); end
    drain(base + 4, ok);
    total++; if (!ok) $display("FAIL round_results: got %0d want 4", got_q.size() - base); else pass_cnt++;
    if (ok)
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({got_q[base+i].d, got_q[base+i].c} !== {64'(want[i]), 16'd1})
          $display("FAIL round_%0d: got %0d/%0d want %0d/1", i, got_q[base+i].d, got_q[base+i].c, want[i]);
        else pass_cnt++;
      end
  endtask

  task automatic test_bubbles;
    int base = got_q.size();
    bit ok;
    for (int k = 1; k <= 5; k++) begin
      send(sc(k), k == 5);
      idle($urandom_range(0, 3));
    end
    drain(base + 1, ok);
    total++; if (got_q.size() !== base + 1) $display("FAIL bubble_result_count: got %0d want 1", got_q.size() - base); else pass_cnt++;
    if (ok) begin
      total++; if (got_q[base].d !== 64'sd15) $display("FAIL bubble_data: got %0d want 15", got_q[base].d); else pass_cnt++;
      total++; if ({got_q[base].s, got_q[base].c} !== {1'b0, 16'd5}) $display("FAIL bubble_sat_count: got %b/%0d want 0/5", got_q[base].s, got_q[base].c); else pass_cnt++;
    end
  endtask

  task automatic test_saturation;
    int base = got_q.size();
    bit ok;
    for (int k = 0; k < 8; k++) send(PMAX, k == 7);
    send(sc(-2), 1'b1);
    drain(base + 2, ok);
    total++; if (!ok) $display("FAIL sat_results: got %0d want 2", got_q.size() - base); else pass_cnt++;
    if (ok) begin
      total++; if (got_q[base].d !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL sat_data: got %h want 7fffffffffffffff", got_q[base].d); else pass_cnt++;
      total++; if ({got_q[base].s, got_q[base].c} !== {1'b1, 16'd8}) $display("FAIL sat_flag_count: got %b/%0d want 1/8", got_q[base].s, got_q[base].c); else pass_cnt++;
      total++; if ({got_q[base+1].d, got_q[base+1].s} !== {-64'sd2, 1'b0}) $display("FAIL sat_next_group: got %0d/%b want -2/0", got_q[base+1].d, got_q[base+1].s); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    int base = got_q.size();
    bit ok;
    mode = 2;
    send(sc(9), 1'b1);
    send(sc(1), 1'b0);
    send(sc(2), 1'b0);
    send(sc(3), 1'b1);
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick(1);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.mul_ce, bus.in_ready, bus.out_valid, bus.out_data} !== {3'b001, 64'sd9})
        $display("FAIL hold_cycle_%0d: got ce=%b rdy=%b v=%b d=%0d want 0/0/1/9", i, bus.mul_ce, bus.in_ready, bus.out_valid, bus.out_data);
      else pass_cnt++;
      tick(1);
    end
    total++; if (got_q.size() !== base) $display("FAIL hold_no_accept: got %0d want 0", got_q.size() - base); else pass_cnt++;
    mode = 0;
    drain(base + 2, ok);
    total++; if (got_q.size() !== base + 2) $display("FAIL release_results: got %0d want 2", got_q.size() - base); else pass_cnt++;
    if (ok) begin
      total++; if ({got_q[base].d, got_q[base].c} !== {64'sd9, 16'd1}) $display("FAIL release_first: got %0d/%0d want 9/1", got_q[base].d, got_q[base].c); else pass_cnt++;
      total++; if ({got_q[base+1].d, got_q[base+1].c} !== {64'sd6, 16'd3}) $display("FAIL release_second: got %0d/%0d want 6/3", got_q[base+1].d, got_q[base+1].c); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit ok;
    send(sc(1), 1'b0);
    send(sc(2), 1'b0);
    reset_n = 1'b0;
    tick(1);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_sat, bus.out_count} !== '0)
      $display("FAIL midreset_outputs: got v=%b d=%0d s=%b c=%0d want all 0", bus.out_valid, bus.out_data, bus.out_sat, bus.out_count);
    else pass_cnt++;
    tick(1);
    reset_n = 1'b1;
    m_acc = '0;
    m_sat = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    base = got_q.size();
    send(sc(7), 1'b1);
    drain(base + 1, ok);
    total++; if (got_q.size() !== base + 1) $display("FAIL midreset_results: got %0d want 1", got_q.size() - base); else pass_cnt++;
    if (ok) begin
      total++;
      if (got_q[base] !== res_t'{64'sd7, 1'b0, 16'd1})
        $display("FAIL midreset_group: got %0d/%b/%0d want 7/0/1", got_q[base].d, got_q[base].s, got_q[base].c);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int base = got_q.size();
    bit ok;
    exp_q.delete();
    for (int k = 0; k < 6; k++) send(sc(longint'($urandom_range(0, 1000)) - 500), 1'b1);
    drain(base + 6, ok);
    total++; if (got_q.size() !== base + 6) $display("FAIL b2b_results: got %0d want 6", got_q.size() - base); else pass_cnt++;
    if (ok)
      for (int i = 0; i < 6; i++) begin
        total++;
        if (got_q[base+i] !== exp_q[i]) $display("FAIL b2b_data_%0d: got %0d want %0d", i, got_q[base+i].d, exp_q[i].d);
        else pass_cnt++;
        if (i > 0) begin
          total++;
          if (got_t[base+i] !== got_t[base+i-1] + 1)
            $display("FAIL b2b_gap_%0d: got %0d cycles want 1", i, got_t[base+i] - got_t[base+i-1]);
          else pass_cnt++;
        end
      end
  endtask

  task automatic test_random;
    int base = got_q.size();
    int len;
    int k;
    bit ok;
    logic signed [92:0] p;
    exp_q.delete();
    mode = 1;
    for (int g = 0; g < 25; g++) begin
      len = $urandom_range(1, 10);
      for (int t = 0; t < len; t++) begin
        k = $urandom_range(0, 7);
        p = k == 0 ? PMAX : k == 1 ? PMIN : rnd93();
        send(p, t == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    drain(base + exp_q.size(), ok);
    mode = 0;
    total++; if (got_q.size() !== base + exp_q.size()) $display("FAIL rand_results: got %0d want %0d", got_q.size() - base, exp_q.size()); else pass_cnt++;
    if (ok)
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[base+i] !== exp_q[i])
          $display("FAIL rand_group_%0d: got %0d/%b/%0d want %0d/%b/%0d", i, got_q[base+i].d, got_q[base+i].s, got_q[base+i].c, exp_q[i].d, exp_q[i].s, exp_q[i].c);
        else pass_cnt++;
      end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    test_reset;
    test_single;
    test_rounding;
    test_bubbles;
    test_saturation;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
